dist4_frame_sorter_ctrl: RTL and testbench

- Stream-side wrapper for the 4-input combinational distance sorting network in the V2V dist2Sorter datapath.
- Collects up to 4 distance samples per frame from a valid/ready stream and pads short frames.
- Drives the frame onto the external sorter's a0..a3 inputs, registers the sorter's y0..y3 result, and presents it downstream with a valid/ready handshake.
- Feeds the sorter and consumes its outputs; the sorter itself stays outside this block.

---
 rtl/dist2_sorter_pkg.sv | 21 ++
 rtl/dist4_slot_buffer.sv | 69 ++++++
 rtl/dist4_frame_sorter_ctrl.sv | 146 ++++++++++++++
 tb/tb_dist4_frame_sorter_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist2_sorter_pkg.sv
// Shared types and constants for the 4-input distance sorter stream wrapper.
package dist2_sorter_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    OUTPUT  = 2'd2
  } sorter_state_e;

  localparam int FRAME_SLOTS = 4;
  localparam int COUNT_W     = 3;
  localparam int PAD_MAX_W   = 64;

  // Padding sorts after every real sample, so it is the largest unsigned value.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input int width);
    logic [PAD_MAX_W-1:0] v;
    v = {PAD_MAX_W{1'b1}} >> (PAD_MAX_W - width);
    return v;
  endfunction

endpackage

// File: rtl/dist4_slot_buffer.sv
// Four-slot frame register file: writes samples in arrival order, counts them,
// and reloads every slot to the PAD value on clear or reset.
module dist4_slot_buffer
  import dist2_sorter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en_i,
  input  logic [WIDTH-1:0]                      wr_data_i,
  input  logic                                  clr_i,
  output logic [FRAME_SLOTS-1:0][WIDTH-1:0]     slots_o,
  output logic [COUNT_W-1:0]                    count_o
);

  localparam logic [PAD_MAX_W-1:0] PAD_WIDE = pad_value(WIDTH);
  localparam logic [WIDTH-1:0]     PAD      = PAD_WIDE[WIDTH-1:0];

  logic [COUNT_W-1:0] count_q, count_d;
  logic               can_write;

  assign can_write = wr_en_i && (count_q < COUNT_W'(FRAME_SLOTS));

  generate
    for (genvar gi = 0; gi < FRAME_SLOTS; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_q, slot_d;

      always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
          slot_d = PAD;
        end else if (can_write && (count_q == COUNT_W'(gi))) begin
          slot_d = wr_data_i;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= PAD;
        end else begin
          slot_q <= slot_d;
        end
      end

      assign slots_o[gi] = slot_q;
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (can_write) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dist4_frame_sorter_ctrl.sv
// Stream wrapper around an external 4-input sorting network: collects a frame,
// holds it on sort_a for one cycle, registers sort_y and hands it downstream.
// Optional idle timeout for partial frames: define DIST4_FRAME_SORTER_TIMEOUT_EN.
module dist4_frame_sorter_ctrl
  import dist2_sorter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic [WIDTH-1:0]   sort_a0,
  output logic [WIDTH-1:0]   sort_a1,
  output logic [WIDTH-1:0]   sort_a2,
  output logic [WIDTH-1:0]   sort_a3,
  input  logic [WIDTH-1:0]   sort_y0,
  input  logic [WIDTH-1:0]   sort_y1,
  input  logic [WIDTH-1:0]   sort_y2,
  input  logic [WIDTH-1:0]   sort_y3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_d0,
  output logic [WIDTH-1:0]   out_d1,
  output logic [WIDTH-1:0]   out_d2,
  output logic [WIDTH-1:0]   out_d3,
  output logic [2:0]         out_count
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  sorter_state_e                    state_q, state_d;
  logic                             accept;
  logic                             close_frame;
  logic                             timeout_hit;
  logic                             buf_wr;
  logic                             buf_clr;
  logic                             capture;
  logic [FRAME_SLOTS-1:0][WIDTH-1:0] slots;
  logic [COUNT_W-1:0]               count;
  logic [FRAME_SLOTS-1:0][WIDTH-1:0] out_q;
  logic [COUNT_W-1:0]               out_count_q;

  // Gating with rst_n keeps in_ready low for the whole reset assertion.
  assign in_ready = rst_n && (state_q == COLLECT);
  assign accept   = in_valid && in_ready;

  dist4_slot_buffer #(
    .WIDTH (WIDTH)
  ) u_slot_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (buf_wr),
    .wr_data_i (in_data),
    .clr_i     (buf_clr),
    .slots_o   (slots),
    .count_o   (count)
  );

`ifdef DIST4_FRAME_SORTER_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if ((state_q != COLLECT) || (count == '0) || accept) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th idle cycle; an accept in that cycle joins the frame.
  assign timeout_hit = (state_q == COLLECT) && (count != '0) &&
                       (({1'b0, idle_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign close_frame = (accept && (in_last || (count == COUNT_W'(FRAME_SLOTS - 1)))) ||
                       timeout_hit;

  always_comb begin
    state_d = state_q;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    capture = 1'b0;
    case (state_q)
      COLLECT: begin
        buf_wr = accept;
        if (close_frame) begin
          state_d = SORT;
        end
      end
      SORT: begin
        capture = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          buf_clr = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      out_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        out_q       <= {sort_y3, sort_y2, sort_y1, sort_y0};
        out_count_q <= count;
      end
    end
  end

  assign sort_a0   = slots[0];
  assign sort_a1   = slots[1];
  assign sort_a2   = slots[2];
  assign sort_a3   = slots[3];
  assign out_valid = (state_q == OUTPUT);
  assign out_d0    = out_q[0];
  assign out_d1    = out_q[1];
  assign out_d2    = out_q[2];
  assign out_d3    = out_q[3];
  assign out_count = out_count_q;

endmodule

// File: tb/tb_dist4_frame_sorter_ctrl.sv
// Self-checking bench for dist4_frame_sorter_ctrl with an external sorter model;
// covers the timeout path when DIST4_FRAME_SORTER_TIMEOUT_EN is defined.
module tb_dist4_frame_sorter_ctrl;

  localparam int W = 16;
  localparam logic [W-1:0] PADV = 16'hFFFF;
`ifdef DIST4_FRAME_SORTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  typedef logic [3:0][W-1:0] quad_t;
  typedef struct {
    quad_t s;
    int    n;
    bit    last_final;
    quad_t e;
    int    hold;
    string name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_last, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data;
  logic [W-1:0] sort_a0, sort_a1, sort_a2, sort_a3;
  logic [W-1:0] sort_y0, sort_y1, sort_y2, sort_y3;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
  logic [2:0]   out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dist4_frame_sorter_ctrl #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .sort_a0   (sort_a0),
    .sort_a1   (sort_a1),
    .sort_a2   (sort_a2),
    .sort_a3   (sort_a3),
    .sort_y0   (sort_y0),
    .sort_y1   (sort_y1),
    .sort_y2   (sort_y2),
    .sort_y3   (sort_y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3),
    .out_count (out_count)
  );

  // External sorter stand-in: combinational ascending sort of the four inputs.
  function automatic quad_t sorter4(input quad_t a);
    logic [W-1:0] v [4];
    logic [W-1:0] t;
    quad_t r;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  assign {sort_y3, sort_y2, sort_y1, sort_y0} = sorter4({sort_a3, sort_a2, sort_a1, sort_a0});

  function automatic quad_t mk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: real samples plus PAD fill, sorted ascending as a list.
  function automatic quad_t ref_frame(input quad_t s, input int n);
    logic [W-1:0] q[$];
    quad_t r;
    for (int i = 0; i < 4; i++) q.push_back(i < n ? s[i] : PADV);
    q.sort();
    for (int i = 0; i < 4; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quad(input string name, input quad_t act, input quad_t exp);
    check(name, 64'(act), 64'(exp));
  endtask

  // Entered and left at a negedge with the DUT in COLLECT.
  task automatic run_frame(input string tag, input quad_t s, input int n, input bit last_final,
                           input quad_t e, input int hold, input int gap_max, input int stall);
    quad_t slots_exp;
    out_ready = (hold == 0);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (i == 1) gap = gap + stall;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      if (i == 1 && stall > 0) begin
        check({tag, " stall_valid"}, 64'(out_valid), 64'd0);
        check({tag, " stall_ready"}, 64'(in_ready), 64'd1);
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == n - 1) && ((n < 4) || last_final);
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
    for (int i = 0; i < 4; i++) slots_exp[i] = (i < n) ? s[i] : PADV;
    check({tag, " sort_valid"}, 64'(out_valid), 64'd0);
    check({tag, " sort_ready"}, 64'(in_ready), 64'd0);
    check_quad({tag, " sort_a"}, {sort_a3, sort_a2, sort_a1, sort_a0}, slots_exp);
    @(negedge clk);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check_quad({tag, " out_d"}, {out_d3, out_d2, out_d1, out_d0}, e);
    check({tag, " out_count"}, 64'(out_count), 64'(n));
    $display("frame %s n=%0d out_d=%h %h %h %h count=%0d hold=%0d", tag, n,
             out_d0, out_d1, out_d2, out_d3, out_count, hold);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 16'h1234;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, " hold_ready"}, 64'(in_ready), 64'd0);
        check_quad({tag, " hold_d"}, {out_d3, out_d2, out_d1, out_d0}, e);
        check({tag, " hold_count"}, 64'(out_count), 64'(n));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post_valid"}, 64'(out_valid), 64'd0);
    check({tag, " post_ready"}, 64'(in_ready), 64'd1);
    check_quad({tag, " post_pad"}, {sort_a3, sort_a2, sort_a1, sort_a0}, {4{PADV}});
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{s: mk(40, 10, 30, 20), n: 4, last_final: 1'b0, e: mk(10, 20, 30, 40), hold: 0, name: "full"};
    tbl[1] = '{s: mk(7, 3, 0, 0), n: 2, last_final: 1'b1, e: mk(3, 7, PADV, PADV), hold: 0, name: "short"};
    tbl[2] = '{s: mk(100, 50, 75, 0), n: 3, last_final: 1'b1, e: mk(50, 75, 100, PADV), hold: 5, name: "backpressure"};
    tbl[3] = '{s: mk(5, 5, PADV, 0), n: 4, last_final: 1'b1, e: mk(0, 5, 5, PADV), hold: 0, name: "ties_max"};
    tbl[4] = '{s: mk(PADV, 0, 0, 0), n: 1, last_final: 1'b1, e: mk(PADV, PADV, PADV, PADV), hold: 1, name: "single_ones"};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check_quad("rst out_d", {out_d3, out_d2, out_d1, out_d0}, '0);
    check("rst out_count", 64'(out_count), 64'd0);
    check_quad("rst sort_a", {sort_a3, sort_a2, sort_a1, sort_a0}, {4{PADV}});
    rst_n = 1'b1;
    #1;
    check("rel in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].name, tbl[i].s, tbl[i].n, tbl[i].last_final, tbl[i].e, tbl[i].hold, 0, 0);

    // Reset with a partial frame in flight.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = W'(i + 60); in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_quad("midrst sort_a", {sort_a3, sort_a2, sort_a1, sort_a0}, {4{PADV}});
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    $display("reset mid-frame applied sort_a=%h %h %h %h", sort_a0, sort_a1, sort_a2, sort_a3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst rel_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    run_frame("after_reset", mk(9, 1, 8, 2), 4, 1'b0, mk(1, 2, 8, 9), 0, 0, 0);

    // Reset while holding an output.
    in_valid = 1'b1; in_data = 16'd77; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("holdrst pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("holdrst out_valid", 64'(out_valid), 64'd0);
    check("holdrst out_count", 64'(out_count), 64'd0);
    $display("reset during output hold out_valid=%0d", out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DIST4_FRAME_SORTER_TIMEOUT_EN
    begin
      int k;
      in_valid = 1'b1; in_data = 16'd12; in_last = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("timeout latency", 64'(k), 64'd5);
      check_quad("timeout out_d", {out_d3, out_d2, out_d1, out_d0}, mk(12, PADV, PADV, PADV));
      check("timeout out_count", 64'(out_count), 64'd1);
      $display("frame timeout n=1 out_d=%h %h %h %h count=%0d wait=%0d",
               out_d0, out_d1, out_d2, out_d3, out_count, k);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("timeout post_valid", 64'(out_valid), 64'd0);
    end
`else
    run_frame("no_timeout", mk(33, 22, 0, 0), 2, 1'b1, mk(22, 33, PADV, PADV), 0, 0, 300);
`endif

    for (int r = 0; r < 25; r++) begin
      quad_t s;
      int n;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0: s[i] = PADV;
          1: s[i] = '0;
          2: s[i] = (i > 0) ? s[i-1] : W'($urandom);
          default: s[i] = W'($urandom);
        endcase
      end
      n = int'($urandom_range(1, 4));
      run_frame($sformatf("rand%0d", r), s, n, 1'($urandom), ref_frame(s, n),
                int'($urandom_range(0, 3)), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
